ahb_dma_ch_scheduler: RTL and testbench
=======================================

// Module: ahb_dma_ch_scheduler
// PURPOSE
//  Parametrised channel scheduler for the next-generation AHB DMA: counts per-channel peripheral/software requests,
//  picks one eligible channel by programmable priority (fixed or round-robin tie-break), hands it to the DMA engine
//  with a valid/ready grant and returns a one-cycle ack to the requester when the engine finishes the chunk.
//  Sits between the peripheral request lines, the register file (enables/priorities) and the DMA engine.
// PARAMETERS
//  NUM_CH    16  number of channels (2..32); CH_W = $clog2(NUM_CH) is a derived localparam
//  PRI_BITS  2   priority field width per channel; larger value = higher priority
//  PEND_W    4   pending-request counter width per channel; saturates at 2**PEND_W-1
//  RR_EN     1   1: round-robin among equal-priority winners; 0: lowest channel index wins ties
// PORTS
//  clk_i          in   1                 system clock
//  rst_i          in   1                 asynchronous active-low reset
//  ch_en_i        in   NUM_CH            channel enable from register file
//  ch_pri_i       in   NUM_CH*PRI_BITS   priority, channel n at [n*PRI_BITS +: PRI_BITS]
//  req_i          in   NUM_CH            peripheral request levels (rising edge = one request)
//  sw_start_i     in   NUM_CH            one-cycle software request pulses
//  ovf_clr_i      in   NUM_CH            one-cycle pulses clearing pend_ovf_o bits
//  grant_valid_o  out  1                 grant offered to engine
//  grant_ch_o     out  CH_W              granted channel index
//  eng_ready_i    in   1                 engine accepts grant (handshake with grant_valid_o)
//  eng_done_i     in   1                 engine finished the chunk of the accepted channel
//  ack_o          out  NUM_CH            one-cycle ack pulse to requesting peripheral
//  pend_ovf_o     out  NUM_CH            sticky: request arrived while counter saturated
//  busy_o         out  1                 high in GRANT or ACTIVE
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, req edge registers 0, state IDLE, RR pointer 0 (last-granted = NUM_CH-1).
//  Request counting: inc[n] = (req_i[n] & ~req_q[n]) | sw_start_i[n], gated by ch_en_i[n]; both in one cycle = one inc.
//  dec[n] = accepted chunk of channel n completes (eng_done_i in ACTIVE, channel still enabled).
//  inc & dec same cycle: counter unchanged. inc at max: counter holds, pend_ovf_o[n] set (ovf_clr_i same cycle: set wins).
//  ch_en_i[n] low: counter[n] forced 0 next cycle; incoming requests dropped; ovf bit unaffected.
//  Eligible[n] = ch_en_i[n] & counter[n]!=0 & not the channel currently in GRANT/ACTIVE.
//  Selection: max priority among eligible; ties -> RR_EN=1: first index after last-granted (wrapping);
//    RR_EN=0: lowest index. Last-granted updates only on handshake.
//  FSM IDLE: if any eligible, register winner into grant_ch_o, grant_valid_o<=1, go GRANT (latency: grant_valid_o high
//    the cycle after counter becomes non-zero).
//  GRANT: hold grant_valid_o/grant_ch_o stable until eng_ready_i; on eng_ready_i & grant_valid_o -> ACTIVE,
//    grant_valid_o<=0. If ch_en_i[grant] drops before handshake: withdraw, grant_valid_o<=0, -> IDLE, no ack.
//    Higher-priority request arriving during GRANT does not pre-empt.
//  ACTIVE: wait eng_done_i; then ack_o[grant] pulses for exactly one cycle (next cycle), counter decrements, -> IDLE.
//    Channel disabled during ACTIVE: still wait eng_done_i, no ack, counter already cleared.
//  Minimum one IDLE cycle between successive grants; eng_done_i outside ACTIVE and eng_ready_i outside GRANT ignored.
//  Async reset mid-operation: all state cleared immediately; pending requests lost; no ack emitted.
//  grant_ch_o holds last value in IDLE/ACTIVE (meaningful only when grant_valid_o or busy_o).
// TESTING
//  1 Fixed priority: RR_EN=0, ch3 pri 1, ch7 pri 3, both req edges same cycle -> grant ch7 first, then ch3; ack_o=0x0080 then 0x0008.
//  2 Round-robin: ch0,ch1,ch2 pri 2, each 2 sw_start pulses, engine ready/done immediately -> grant order 0,1,2,0,1,2; counters end 0.
//  3 Saturation: PEND_W=2, 4 req edges on ch5 while ch5 disabled-engine never ready -> counter 3, pend_ovf_o[5]=1; ovf_clr_i[5] -> 0.
//  4 Inc/dec collision: ch2 count 2, req edge in same cycle as eng_done_i for ch2 -> count stays 2, ack_o[2] pulses once.
//  5 Disable mid-grant: ch4 in GRANT, eng_ready_i=0, ch_en_i[4]->0 -> grant_valid_o drops next cycle, no ack, counter 0, next eligible granted.
//  6 Reset mid-ACTIVE: assert rst_i low asynchronously -> busy_o, grant_valid_o, ack_o, counters 0 without clock edge; no ack after release.

Source files
------------

// File: rtl/ahb_dma_ch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ahb_dma_ch_scheduler
// Description : AHB DMA channel scheduler. Per-channel request counting,
//               priority and round-robin selection, valid/ready grant and
//               per-chunk ack.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_dma_ch_scheduler #(
    parameter int NUM_CH   = 16,
    parameter int PRI_BITS = 2,
    parameter int PEND_W   = 4,
    parameter bit RR_EN    = 1'b1,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH-1:0]          ch_en_i,
    input  logic [NUM_CH*PRI_BITS-1:0] ch_pri_i,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH-1:0]          sw_start_i,
    input  logic [NUM_CH-1:0]          ovf_clr_i,
    output logic                       grant_valid_o,
    output logic [CH_W-1:0]            grant_ch_o,
    input  logic                       eng_ready_i,
    input  logic                       eng_done_i,
    output logic [NUM_CH-1:0]          ack_o,
    output logic [NUM_CH-1:0]          pend_ovf_o,
    output logic                       busy_o
);

    localparam logic [PEND_W-1:0] c_cnt_max  = {PEND_W{1'b1}};
    localparam logic [1:0]        c_s_idle   = 2'd0;
    localparam logic [1:0]        c_s_grant  = 2'd1;
    localparam logic [1:0]        c_s_active = 2'd2;

    logic [1:0]          r_state;
    logic                r_grant_valid;
    logic                r_busy;
    logic [CH_W-1:0]     r_grant_ch;
    logic [CH_W-1:0]     r_last;
    logic [NUM_CH-1:0]   r_ack;
    logic [NUM_CH-1:0]   r_req_q;

    logic [NUM_CH-1:0]   w_inc;
    logic [NUM_CH-1:0]   w_dec;
    logic [NUM_CH-1:0]   w_cnt_nz;
    logic [NUM_CH-1:0]   w_elig;
    logic [NUM_CH-1:0]   w_cand;
    logic [PRI_BITS-1:0] w_max_pri;
    logic [CH_W-1:0]     w_winner;
    logic                w_found;
    int                  w_idx;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_req_q <= '0;
        end else begin
            r_req_q <= req_i;
        end
    end

    always_comb begin
        w_inc = ((req_i & ~r_req_q) | sw_start_i) & ch_en_i;
        w_dec = '0;
        if (r_state == c_s_active && eng_done_i) begin
            w_dec[r_grant_ch] = ch_en_i[r_grant_ch];
        end
    end

    // Per-channel pending counter and sticky overflow flag
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [PEND_W-1:0] r_cnt;
        logic              r_ovf;
        logic              w_at_max;

        assign w_at_max      = (r_cnt == c_cnt_max);
        assign w_cnt_nz[n]   = |r_cnt;
        assign pend_ovf_o[n] = r_ovf;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (!ch_en_i[n]) begin
                    r_cnt <= '0;
                end else if (w_inc[n] && !w_dec[n]) begin
                    if (!w_at_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else if (w_dec[n] && !w_inc[n] && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end

                if (w_inc[n] && !w_dec[n] && w_at_max) begin
                    r_ovf <= 1'b1;
                end else if (ovf_clr_i[n]) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_elig[n] = ch_en_i[n] && w_cnt_nz[n] &&
                        !((r_state != c_s_idle) && (r_grant_ch == CH_W'(n)));
        end
    end

    always_comb begin
        w_max_pri = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (w_elig[n] && (ch_pri_i[n*PRI_BITS +: PRI_BITS] > w_max_pri)) begin
                w_max_pri = ch_pri_i[n*PRI_BITS +: PRI_BITS];
            end
        end
        for (int n = 0; n < NUM_CH; n++) begin
            w_cand[n] = w_elig[n] && (ch_pri_i[n*PRI_BITS +: PRI_BITS] == w_max_pri);
        end
    end

    // Scan starts just after the last-granted channel (RR) or at channel 0
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (RR_EN) begin
                w_idx = int'(r_last) + k;
                if (w_idx >= NUM_CH) begin
                    w_idx = w_idx - NUM_CH;
                end
            end else begin
                w_idx = k - 1;
            end
            if (!w_found && w_cand[w_idx]) begin
                w_winner = CH_W'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= c_s_idle;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_ch    <= '0;
            r_last        <= CH_W'(NUM_CH - 1);
            r_ack         <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                c_s_idle: begin
                    if (w_found) begin
                        r_grant_ch    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= c_s_grant;
                    end
                end
                c_s_grant: begin
                    if (!ch_en_i[r_grant_ch]) begin
                        r_grant_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= c_s_idle;
                    end else if (eng_ready_i) begin
                        r_grant_valid <= 1'b0;
                        r_last        <= r_grant_ch;
                        r_state       <= c_s_active;
                    end
                end
                c_s_active: begin
                    if (eng_done_i) begin
                        r_ack   <= w_dec;
                        r_busy  <= 1'b0;
                        r_state <= c_s_idle;
                    end
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= c_s_idle;
                end
            endcase
        end
    end

    assign grant_valid_o = r_grant_valid;
    assign grant_ch_o    = r_grant_ch;
    assign ack_o         = r_ack;
    assign busy_o        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ahb_dma_ch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_dma_ch_scheduler
// Description : Scoreboard bench for ahb_dma_ch_scheduler (8 channels,
//               2-bit pending counters, round-robin tie-break).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_dma_ch_scheduler;

    localparam int NUM_CH   = 8;
    localparam int PRI_BITS = 2;
    localparam int PEND_W   = 2;
    localparam bit RR_EN    = 1'b1;
    localparam int CH_W     = 3;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_CH-1:0]          ch_en;
    logic [NUM_CH*PRI_BITS-1:0] ch_pri;
    logic [NUM_CH-1:0]          req;
    logic [NUM_CH-1:0]          sw_start;
    logic [NUM_CH-1:0]          ovf_clr;
    logic                       eng_ready;
    logic                       eng_done;
    logic                       grant_valid_o;
    logic [CH_W-1:0]            grant_ch_o;
    logic [NUM_CH-1:0]          ack_o;
    logic [NUM_CH-1:0]          pend_ovf_o;
    logic                       busy_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    ahb_dma_ch_scheduler #(
        .NUM_CH   (NUM_CH),
        .PRI_BITS (PRI_BITS),
        .PEND_W   (PEND_W),
        .RR_EN    (RR_EN)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .ch_en_i       (ch_en),
        .ch_pri_i      (ch_pri),
        .req_i         (req),
        .sw_start_i    (sw_start),
        .ovf_clr_i     (ovf_clr),
        .grant_valid_o (grant_valid_o),
        .grant_ch_o    (grant_ch_o),
        .eng_ready_i   (eng_ready),
        .eng_done_i    (eng_done),
        .ack_o         (ack_o),
        .pend_ovf_o    (pend_ovf_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: every queued channel must be granted in order
    task automatic serve_all();
        int t;
        int exp_ch;
        logic [CH_W-1:0]   exp_g;
        logic [NUM_CH-1:0] exp_ack;
        while (exp_q.size() > 0) begin
            t = 0;
            while (grant_valid_o !== 1'b1 && t < 40) begin
                @(negedge clk);
                t++;
            end
            exp_ch  = exp_q.pop_front();
            exp_g   = CH_W'(exp_ch);
            exp_ack = NUM_CH'(1 << exp_ch);
            checks++;
            if (grant_valid_o !== 1'b1) begin
                $display("FAIL grant_timeout: grant_valid_o=%b required 1 for ch %0d", grant_valid_o, exp_ch);
                errors++;
                exp_q.delete();
                return;
            end
            checks++;
            if (grant_ch_o !== exp_g) begin
                $display("FAIL grant_order: grant_ch_o=%0d required %0d", grant_ch_o, exp_g);
                errors++;
            end
            eng_ready = 1'b1;
            @(negedge clk);
            eng_ready = 1'b0;
            checks++;
            if (grant_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                $display("FAIL handshake: grant_valid_o=%b busy_o=%b required 0 1", grant_valid_o, busy_o);
                errors++;
            end
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
            checks++;
            if (ack_o !== exp_ack) begin
                $display("FAIL ack: ack_o=%h required %h", ack_o, exp_ack);
                errors++;
            end
            @(negedge clk);
            checks++;
            if (ack_o !== '0) begin
                $display("FAIL ack_pulse: ack_o=%h required 00", ack_o);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ch_en     = '0;
        ch_pri    = '0;
        req       = '0;
        sw_start  = '0;
        ovf_clr   = '0;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (grant_valid_o !== 1'b0 || busy_o !== 1'b0 || ack_o !== '0 ||
            pend_ovf_o !== '0 || grant_ch_o !== '0) begin
            $display("FAIL reset_state: gv=%b busy=%b ack=%h ovf=%h ch=%0d required all 0",
                     grant_valid_o, busy_o, ack_o, pend_ovf_o, grant_ch_o);
            errors++;
        end
        rst_n = 1'b1;
        ch_en = '1;
        @(negedge clk);
        checks++;
        if (grant_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL reset_release: gv=%b busy=%b required 0 0", grant_valid_o, busy_o);
            errors++;
        end
    endtask

    task automatic test_fixed_priority();
        int t;
        ch_pri = '0;
        ch_pri[3*PRI_BITS +: PRI_BITS] = 2'd1;
        ch_pri[7*PRI_BITS +: PRI_BITS] = 2'd3;
        req[3] = 1'b1;
        req[7] = 1'b1;
        exp_q.push_back(7);
        exp_q.push_back(3);
        @(negedge clk);
        checks++;
        if (grant_valid_o !== 1'b0) begin
            $display("FAIL grant_latency: grant_valid_o=%b required 0 one cycle after edge", grant_valid_o);
            errors++;
        end
        req = '0;
        serve_all();
        t = 0;
        repeat (12) begin
            @(negedge clk);
            if (grant_valid_o !== 1'b0 || ack_o !== '0) t++;
        end
        checks++;
        if (t != 0) begin
            $display("FAIL fixed_quiet: %0d active cycles required 0", t);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        int t;
        ch_pri = '0;
        for (int n = 0; n < 3; n++) ch_pri[n*PRI_BITS +: PRI_BITS] = 2'd2;
        sw_start = 8'h07;
        @(negedge clk);
        sw_start = 8'h07;
        @(negedge clk);
        sw_start = '0;
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 3; n++) exp_q.push_back(n);
        end
        serve_all();
        t = 0;
        repeat (12) begin
            @(negedge clk);
            if (grant_valid_o !== 1'b0) t++;
        end
        checks++;
        if (t != 0) begin
            $display("FAIL rr_counters_empty: %0d grant cycles required 0", t);
            errors++;
        end
    endtask

    task automatic test_saturation();
        int t;
        ch_pri = '0;
        ch_pri[5*PRI_BITS +: PRI_BITS] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                checks++;
                if (pend_ovf_o !== '0) begin
                    $display("FAIL ovf_early: pend_ovf_o=%h required 00", pend_ovf_o);
                    errors++;
                end
            end
            req[5] = 1'b1;
            @(negedge clk);
            req[5] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (pend_ovf_o !== 8'h20 || grant_valid_o !== 1'b1 || grant_ch_o !== 3'd5) begin
            $display("FAIL ovf_set: ovf=%h gv=%b ch=%0d required 20 1 5", pend_ovf_o, grant_valid_o, grant_ch_o);
            errors++;
        end
        req[5]     = 1'b1;
        ovf_clr[5] = 1'b1;
        @(negedge clk);
        req[5]  = 1'b0;
        ovf_clr = '0;
        checks++;
        if (pend_ovf_o !== 8'h20) begin
            $display("FAIL ovf_set_wins: pend_ovf_o=%h required 20", pend_ovf_o);
            errors++;
        end
        ovf_clr[5] = 1'b1;
        @(negedge clk);
        ovf_clr = '0;
        checks++;
        if (pend_ovf_o !== 8'h00) begin
            $display("FAIL ovf_clear: pend_ovf_o=%h required 00", pend_ovf_o);
            errors++;
        end
        repeat (3) exp_q.push_back(5);
        serve_all();
        t = 0;
        repeat (12) begin
            @(negedge clk);
            if (grant_valid_o !== 1'b0) t++;
        end
        checks++;
        if (t != 0) begin
            $display("FAIL sat_count: %0d extra grant cycles required 0", t);
            errors++;
        end
    endtask

    task automatic test_collision();
        int t;
        ch_pri = '0;
        ch_pri[2*PRI_BITS +: PRI_BITS] = 2'd1;
        sw_start[2] = 1'b1;
        @(negedge clk);
        sw_start[2] = 1'b1;
        @(negedge clk);
        sw_start = '0;
        t = 0;
        while (grant_valid_o !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (grant_valid_o !== 1'b1 || grant_ch_o !== 3'd2) begin
            $display("FAIL coll_grant: gv=%b ch=%0d required 1 2", grant_valid_o, grant_ch_o);
            errors++;
        end
        eng_ready = 1'b1;
        @(negedge clk);
        eng_ready = 1'b0;
        eng_done  = 1'b1;
        req[2]    = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        checks++;
        if (ack_o !== 8'h04) begin
            $display("FAIL coll_ack: ack_o=%h required 04", ack_o);
            errors++;
        end
        @(negedge clk);
        req[2] = 1'b0;
        checks++;
        if (ack_o !== 8'h00) begin
            $display("FAIL coll_ack_once: ack_o=%h required 00", ack_o);
            errors++;
        end
        exp_q.push_back(2);
        exp_q.push_back(2);
        serve_all();
        t = 0;
        repeat (12) begin
            @(negedge clk);
            if (grant_valid_o !== 1'b0) t++;
        end
        checks++;
        if (t != 0) begin
            $display("FAIL coll_count: %0d extra grant cycles required 0", t);
            errors++;
        end
    endtask

    task automatic test_disable_grant();
        int t;
        ch_pri = '0;
        ch_pri[4*PRI_BITS +: PRI_BITS] = 2'd3;
        ch_pri[6*PRI_BITS +: PRI_BITS] = 2'd1;
        sw_start = 8'h50;
        @(negedge clk);
        sw_start = '0;
        t = 0;
        while (grant_valid_o !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (grant_valid_o !== 1'b1 || grant_ch_o !== 3'd4) begin
            $display("FAIL dis_hold: gv=%b ch=%0d required 1 4", grant_valid_o, grant_ch_o);
            errors++;
        end
        ch_en[4] = 1'b0;
        @(negedge clk);
        ch_en[4] = 1'b1;
        checks++;
        if (grant_valid_o !== 1'b0 || busy_o !== 1'b0 || ack_o !== '0) begin
            $display("FAIL dis_withdraw: gv=%b busy=%b ack=%h required 0 0 00", grant_valid_o, busy_o, ack_o);
            errors++;
        end
        exp_q.push_back(6);
        serve_all();
        t = 0;
        repeat (12) begin
            @(negedge clk);
            if (grant_valid_o !== 1'b0 || ack_o !== '0) t++;
        end
        checks++;
        if (t != 0) begin
            $display("FAIL dis_counter_cleared: %0d active cycles required 0", t);
            errors++;
        end
    endtask

    task automatic test_reset_active();
        int t;
        ch_pri = '0;
        ch_pri[1*PRI_BITS +: PRI_BITS] = 2'd2;
        repeat (4) begin
            sw_start[1] = 1'b1;
            @(negedge clk);
        end
        sw_start = '0;
        t = 0;
        while (grant_valid_o !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (grant_ch_o !== 3'd1 || pend_ovf_o !== 8'h02) begin
            $display("FAIL rst_setup: ch=%0d ovf=%h required 1 02", grant_ch_o, pend_ovf_o);
            errors++;
        end
        eng_ready = 1'b1;
        @(negedge clk);
        eng_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || grant_valid_o !== 1'b0 || ack_o !== '0 || pend_ovf_o !== '0) begin
            $display("FAIL async_reset: busy=%b gv=%b ack=%h ovf=%h required 0 0 00 00",
                     busy_o, grant_valid_o, ack_o, pend_ovf_o);
            errors++;
        end
        @(negedge clk);
        rst_n    = 1'b1;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        t = 0;
        repeat (12) begin
            if (grant_valid_o !== 1'b0 || ack_o !== '0 || busy_o !== 1'b0) t++;
            @(negedge clk);
        end
        checks++;
        if (t != 0) begin
            $display("FAIL rst_no_ack: %0d active cycles required 0", t);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_saturation();
        test_collision();
        test_disable_grant();
        test_reset_active();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
